timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
Memory-mapped programmable down-counter timer. It is the interrupt source directly upstream of the CP0 coprocessor.
- Its irq output drives one bit of CP0's HWInt[5:0] bus.
- The bus bridge instantiates it and exposes three 32-bit word registers to sw/lw.
- Supports one-shot and auto-reload modes, with a maskable level interrupt.

Parameters:
- WIDTH, 32, width of the PRESET and COUNT registers and of the data bus.
- RST_PRESET, 0, reset value of the PRESET register.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the bridge; only addr[3:2] is decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved).
- we  in  1  write strobe, qualified by the bridge's chip select.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  combinational read of the register selected by addr[3:2].
- irq  out  1  interrupt request to CP0 HWInt.

Behaviour:
- CTRL register bits:
  - [0] EN, enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 10 and 11 treated as 00.
  - [3] IM, interrupt mask; 1 = irq allowed.
  - [31:4] read as 0 and ignore writes.
- PRESET: read/write. COUNT: read-only; writes to it are ignored. Reserved address reads 0.
- Reset: state=IDLE, CTRL=0, PRESET=RST_PRESET, COUNT=0, irq_pending=0. Hence irq=0 and rdata follows addr.
- irq = irq_pending & CTRL[3], combinational from registers.
- FSM states IDLE, LOAD, CNT, INT, evaluated every cycle:
  - IDLE: EN=1 -> LOAD; else stay; COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT. If EN=0 in this cycle -> IDLE, no load.
  - CNT:
    - EN=0 -> IDLE; COUNT holds (pause).
    - COUNT>1 -> COUNT<=COUNT-1.
    - COUNT<=1 -> COUNT<=0, irq_pending<=1, -> INT.
  - INT, MODE=00: EN<=0 (hardware clears CTRL[0]) -> IDLE; irq_pending stays 1.
  - INT, MODE=01: irq_pending<=0 -> LOAD.
- Timing:
  - Auto-reload gives a 1-cycle irq pulse.
  - Reload period is PRESET+2 cycles for PRESET>=1.
  - Cycles from EN write to irq rising equal PRESET+2 for PRESET>=1 (1 IDLE + 1 LOAD + PRESET CNT edges); for PRESET=0, irq rises in the same cycle as PRESET=1.
- Writes (effective at the edge where we=1):
  - Write to CTRL replaces bits [3:0] and clears irq_pending. This is the only way to acknowledge a one-shot irq.
  - If a CTRL write and an FSM transition land on the same edge, the write wins for CTRL and irq_pending. The FSM still moves to its computed next state.
  - Exception: INT one-shot plus a CTRL write with EN=1 leaves CTRL[0]=1, and the FSM goes to IDLE then LOAD.
  - A PRESET write during CNT does not disturb COUNT; the value is used at the next LOAD.
- Width: COUNT decrement is modulo 2^WIDTH but never underflows, because 0 and 1 exit CNT. PRESET=0 behaves like PRESET=1 except COUNT shows 0.
- Reset mid-count: returns everything to reset values on the next edge, and irq drops at that edge.

Decomposition:
- Shared package holds:
  - address offsets TC_CTRL=2'd0, TC_PRESET=2'd1, TC_COUNT=2'd2;
  - CTRL bit indices EN=0, MODE=2:1, IM=3;
  - mode encodings MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01;
  - state encodings IDLE/LOAD/CNT/INT as a 2-bit enum.
- The bridge reuses the offsets.
- No sub-module: register file, FSM and counter stay in one block. The bridge instantiates two copies (timer0, timer1) on HWInt[0] and HWInt[1].

Test Plan:
- Reset, then read all three offsets -> rdata CTRL=0, PRESET=0, COUNT=0; irq=0.
- PRESET=5, then CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1 on successive CNT cycles. irq rises 7 cycles after the CTRL write and stays high. CTRL reads 0x8.
- Acknowledge: with irq high, write CTRL=0x8 -> irq low next cycle, FSM stays IDLE. Write CTRL=0x9 -> new countdown of 5.
- Auto-reload: PRESET=3, CTRL=0xB -> irq 1-cycle pulses every 5 cycles, for at least 3 periods.
- Masked: PRESET=2, CTRL=0x1 -> irq never asserts, CTRL reads 0x0 after expiry. Then write CTRL=0x8 -> irq stays 0, since the write clears pending.
- Pause and reset: PRESET=10, EN=1. At COUNT=6, write CTRL=0x8 -> COUNT holds 6. Assert reset mid-count on a later run -> COUNT=0, CTRL=0, irq=0 next cycle. A PRESET write of 20 during CNT leaves COUNT undisturbed.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the programmable down-counter timer: register offsets,
// CTRL field positions, mode encodings and the FSM state type.
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    // Encodings 10 and 11 fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Word-register bus between the bridge and a timer instance, plus its irq line.
interface timer_counter_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with one-shot / auto-reload modes and a
// maskable level interrupt; register file, FSM and counter live in this block.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_PRESET = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    timer_counter_if.slave     bus
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    tc_state_e        state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pending_q, pending_d;

    logic [1:0]       sel_s;
    logic             en_s;
    logic [1:0]       mode_s;
    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             unused_addr_s;

    assign sel_s         = bus.addr[3:2];
    assign en_s          = ctrl_q[CTRL_EN];
    assign mode_s        = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign ctrl_wr_s     = bus.we && (sel_s == TC_CTRL);
    assign preset_wr_s   = bus.we && (sel_s == TC_PRESET);
    assign unused_addr_s = ^{bus.addr[31:4], bus.addr[1:0]};

    // Next-state logic: FSM/counter first, then bus writes override CTRL and pending.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (en_s) begin
                    count_d = preset_q;
                    state_d = CNT;
                end else begin
                    state_d = IDLE;
                end
            end
            CNT: begin
                if (!en_s) begin
                    state_d = IDLE;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else begin
                    count_d   = ZERO;
                    pending_d = 1'b1;
                    state_d   = INT;
                end
            end
            INT: begin
                if (is_reload(mode_s)) begin
                    pending_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A CTRL write is also the acknowledge for a pending interrupt.
        if (ctrl_wr_s) begin
            ctrl_d    = bus.wdata[3:0];
            pending_d = 1'b0;
        end else begin
            ctrl_d = ctrl_d;
        end

        if (preset_wr_s) begin
            preset_d = bus.wdata;
        end else begin
            preset_d = preset_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= 4'd0;
            preset_q  <= RST_PRESET;
            count_q   <= ZERO;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Combinational read mux on the word offset.
    always_comb begin
        case (sel_s)
            TC_CTRL:   bus.rdata = {{(WIDTH-4){1'b0}}, ctrl_q};
            TC_PRESET: bus.rdata = preset_q;
            TC_COUNT:  bus.rdata = count_q;
            default:   bus.rdata = ZERO;
        endcase
    end

    assign bus.irq = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a register-access vector table plus
// directed sequences for one-shot, acknowledge, auto-reload, mask, pause and reset.
module tb_timer_counter;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    timer_counter_if #(.WIDTH(32)) bus ();

    timer_counter #(.WIDTH(32), .RST_PRESET(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Ticks until irq is high or the bound expires; cycles == bound signals timeout.
    task automatic wait_irq(input int bound, output int cycles);
        cycles = 0;
        while (!bus.irq && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_count(input logic [31:0] val, input int bound, input string name);
        int n;
        n = 0;
        bus.addr = A_COUNT;
        #1;
        while (bus.rdata !== val && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'd0, bus.rdata === val}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;
        int          highs;
        logic [31:0] exp_cnt [1:7];

        n_total   = 0;
        n_pass    = 0;
        bus.addr  = 32'h0;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
        reset     = 1'b1;
        tick();
        tick();
        reset     = 1'b0;

        // Register access vectors; EN is never set here so the FSM stays idle.
        vecs[0] = '{A_CTRL,         1'b0, 32'h0,         32'h0,         1'b0};
        vecs[1] = '{A_PRESET,       1'b0, 32'h0,         32'h0,         1'b0};
        vecs[2] = '{A_COUNT,        1'b0, 32'h0,         32'h0,         1'b0};
        vecs[3] = '{A_RSVD,         1'b0, 32'h0,         32'h0,         1'b0};
        vecs[4] = '{A_PRESET,       1'b1, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
        vecs[5] = '{A_COUNT,        1'b1, 32'h0000_1234, 32'h0,         1'b0};
        vecs[6] = '{A_CTRL,         1'b1, 32'hFFFF_FFF6, 32'h6,         1'b0};
        vecs[7] = '{A_RSVD,         1'b1, 32'h0000_0055, 32'h0,         1'b0};
        vecs[8] = '{BASE + 32'h7,   1'b0, 32'h0,         32'hDEADBEEF,  1'b0};
        vecs[9] = '{A_CTRL,         1'b1, 32'h0,         32'h0,         1'b0};

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                tick();
            end
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
        end

        // One-shot: PRESET=5, COUNT after edges 1..7 of the enable write.
        do_reset();
        rd(A_PRESET, d);
        check("reset preset", d, 32'h0);
        exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        bus.addr = A_COUNT;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("oneshot count e%0d", k), bus.rdata, exp_cnt[k]);
            check($sformatf("oneshot irq e%0d", k), {31'd0, bus.irq}, (k == 7) ? 32'd1 : 32'd0);
        end
        tick();
        rd(A_CTRL, d);
        check("oneshot ctrl after expiry", d, 32'h8);
        tick();
        tick();
        check("oneshot irq held", {31'd0, bus.irq}, 32'd1);

        // Acknowledge, then restart the countdown.
        wr(A_CTRL, 32'h8);
        check("ack irq low", {31'd0, bus.irq}, 32'd0);
        tick();
        tick();
        rd(A_COUNT, d);
        check("ack fsm idle count", d, 32'd0);
        check("ack irq stays low", {31'd0, bus.irq}, 32'd0);
        wr(A_CTRL, 32'h9);
        wait_irq(40, cyc);
        check("restart irq latency", cyc, 32'd7);

        // Auto-reload: PRESET=3 gives a one-cycle pulse every 5 cycles.
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        wait_irq(40, cyc);
        check("reload first latency", cyc, 32'd5);
        for (int p = 0; p < 3; p++) begin
            tick();
            check($sformatf("reload pulse end p%0d", p), {31'd0, bus.irq}, 32'd0);
            wait_irq(40, cyc);
            check($sformatf("reload period p%0d", p), cyc + 1, 32'd5);
        end
        rd(A_CTRL, d);
        check("reload ctrl keeps en", d, 32'hB);
        wr(A_CTRL, 32'h0);

        // Masked one-shot never raises irq; a later IM-only write clears pending.
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h1);
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.irq) highs++;
        end
        check("masked irq highs", highs, 32'd0);
        rd(A_CTRL, d);
        check("masked ctrl after expiry", d, 32'h0);
        wr(A_CTRL, 32'h8);
        check("masked then unmask irq", {31'd0, bus.irq}, 32'd0);

        // Pause: the disabling write lands on the edge where COUNT becomes 6.
        do_reset();
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        wait_count(32'd7, 40, "pause reach 7");
        wr(A_CTRL, 32'h8);
        rd(A_COUNT, d);
        check("pause count", d, 32'd6);
        tick();
        tick();
        tick();
        rd(A_COUNT, d);
        check("pause count held", d, 32'd6);
        check("pause irq", {31'd0, bus.irq}, 32'd0);

        // Reset mid-count.
        wr(A_CTRL, 32'h9);
        wait_count(32'd4, 40, "reset run reach 4");
        do_reset();
        rd(A_COUNT, d);
        check("midreset count", d, 32'd0);
        rd(A_CTRL, d);
        check("midreset ctrl", d, 32'h0);
        check("midreset irq", {31'd0, bus.irq}, 32'd0);
        tick();
        tick();
        rd(A_COUNT, d);
        check("midreset stays idle", d, 32'd0);

        // PRESET write during CNT leaves COUNT alone and applies at the next LOAD.
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        wait_count(32'd8, 40, "preset run reach 8");
        wr(A_PRESET, 32'd20);
        rd(A_COUNT, d);
        check("preset write count", d, 32'd7);
        rd(A_PRESET, d);
        check("preset readback", d, 32'd20);
        bus.addr = A_COUNT;
        tick();
        check("preset write count next", bus.rdata, 32'd6);
        wait_irq(40, cyc);
        check("preset run tail", cyc, 32'd6);
        wr(A_CTRL, 32'h9);
        wait_irq(60, cyc);
        check("new preset latency", cyc, 32'd22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
